ss_seq: RTL and testbench

- Save-state sequencer: the initiator side of the mapper save-state port.
- On command it walks ss_addr over the mapper's state space.
- Save: captures each ss_rdat byte into a 256-byte state buffer.
- Load: replays buffer bytes into the mapper by driving data and a synthetic M2 falling edge, which is the edge mapper registers latch on while ss_act is set.
- Sits between the system menu/host controller and the active mapper's ss_ctrl bus.

---
 rtl/ss_seq_pkg.sv | 30 +++
 rtl/ss_seq_timer.sv | 29 ++
 rtl/ss_seq.sv | 166 ++++++++++++++++
 tb/tb_ss_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_seq_pkg.sv
// Shared definitions for the save-state sequencer: FSM states, address width
// and default timing/length constants.
package ss_seq_pkg;

  localparam int unsigned SS_AW        = 8;
  localparam int unsigned SS_LEN_DEF   = 256;
  localparam int unsigned IDX_ADDR_DEF = 127;
  localparam int unsigned RD_WAIT_DEF  = 2;
  localparam int unsigned M2_HI_DEF    = 2;
  localparam int unsigned TMR_W        = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SV_ADDR,
    ST_SV_WAIT,
    ST_SV_STORE,
    ST_LD_CHK,
    ST_LD_FETCH,
    ST_LD_DATA,
    ST_LD_M2H,
    ST_LD_M2L,
    ST_DONE
  } state_t;

  // Preset for a timed state that must last `cycles` clocks (exit on zero).
  function automatic logic [TMR_W-1:0] tmr_preset(input int unsigned cycles);
    return (cycles > 0) ? TMR_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/ss_seq_timer.sv
// Loadable down-counter with zero flag; paces read settle and M2 high time.
module ss_seq_timer
  import ss_seq_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ss_seq.sv
// Save-state sequencer: walks the mapper state space, saving readback into the
// state buffer or replaying buffer bytes into the mapper via synthetic M2.
module ss_seq
  import ss_seq_pkg::*;
#(
  parameter int unsigned SS_LEN   = SS_LEN_DEF,
  parameter int unsigned IDX_ADDR = IDX_ADDR_DEF,
  parameter int unsigned RD_WAIT  = RD_WAIT_DEF,
  parameter int unsigned M2_HI    = M2_HI_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_save,
  input  logic             start_load,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ss_act,
  output logic             ss_we,
  output logic [SS_AW-1:0] ss_addr,
  output logic [7:0]       ss_dout,
  output logic             ss_m2,
  input  logic [7:0]       ss_rdat,
  output logic [SS_AW-1:0] buf_addr,
  output logic [7:0]       buf_wdat,
  output logic             buf_we,
  input  logic [7:0]       buf_rdat
);

  localparam logic [SS_AW-1:0] LAST     = SS_AW'(SS_LEN - 1);
  localparam logic [SS_AW-1:0] IDX      = SS_AW'(IDX_ADDR);
  localparam int unsigned      CHK_WAIT = (RD_WAIT > 1) ? RD_WAIT : 1;
  localparam logic [TMR_W-1:0] SV_PRE   = tmr_preset(RD_WAIT);
  localparam logic [TMR_W-1:0] CHK_PRE  = TMR_W'(CHK_WAIT);
  localparam logic [TMR_W-1:0] M2_PRE   = tmr_preset(M2_HI);

  state_t           state, state_nx;
  logic [SS_AW-1:0] idx;
  logic [7:0]       dout_q;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  logic             idx_clr, idx_inc, err_clr, err_set;

  ss_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      dout_q <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (idx_clr) begin
        idx <= '0;
      end else if (idx_inc) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_LD_DATA) begin
        dout_q <= buf_rdat;
      end
      if (err_clr) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Terminal test precedes increment, so idx never wraps past LAST.
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    err_clr  = 1'b0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_save) begin
          state_nx = ST_SV_ADDR;
          idx_clr  = 1'b1;
          err_clr  = 1'b1;
        end else if (start_load) begin
          state_nx = ST_LD_CHK;
          idx_clr  = 1'b1;
          err_clr  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CHK_PRE;
        end
      end
      ST_SV_ADDR: begin
        tmr_load = 1'b1;
        tmr_val  = SV_PRE;
        state_nx = (RD_WAIT == 0) ? ST_SV_STORE : ST_SV_WAIT;
      end
      ST_SV_WAIT: begin
        if (tmr_zero) state_nx = ST_SV_STORE;
        else          tmr_dec  = 1'b1;
      end
      ST_SV_STORE: begin
        if (idx == LAST) begin
          state_nx = ST_DONE;
        end else begin
          idx_inc  = 1'b1;
          state_nx = ST_SV_ADDR;
        end
      end
      ST_LD_CHK: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (buf_rdat != ss_rdat) begin
          err_set  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          idx_clr  = 1'b1;
          state_nx = ST_LD_FETCH;
        end
      end
      ST_LD_FETCH: state_nx = ST_LD_DATA;
      ST_LD_DATA: begin
        tmr_load = 1'b1;
        tmr_val  = M2_PRE;
        state_nx = ST_LD_M2H;
      end
      ST_LD_M2H: begin
        if (tmr_zero) state_nx = ST_LD_M2L;
        else          tmr_dec  = 1'b1;
      end
      ST_LD_M2L: begin
        if (idx == LAST) begin
          state_nx = ST_DONE;
        end else begin
          idx_inc  = 1'b1;
          state_nx = ST_LD_FETCH;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so async reset drops them at once.
  always_comb begin
    busy     = (state != ST_IDLE) && (state != ST_DONE);
    ss_act   = busy;
    done     = (state == ST_DONE);
    ss_we    = state inside {ST_LD_DATA, ST_LD_M2H, ST_LD_M2L};
    ss_m2    = (state == ST_LD_M2H);
    buf_we   = (state == ST_SV_STORE);
    buf_wdat = buf_we ? ss_rdat : '0;
    ss_addr  = (state == ST_LD_CHK) ? IDX : (busy ? idx : '0);
    buf_addr = ss_addr;
    ss_dout  = (state == ST_LD_DATA) ? buf_rdat : dout_q;
  end

endmodule

// File: tb/tb_ss_seq.sv
// Bench for ss_seq: buffer and mapper models, table vectors, random ops and
// hand-written reset / concurrency sequences.
module tb_ss_seq;

  localparam logic [7:0] IDX      = 8'd127;
  localparam int         SAVE_LAT = 256 * (2 + 2) + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_save = 1'b0, start_load = 1'b0;
  logic       busy, done, err, ss_act, ss_we, ss_m2, buf_we;
  logic [7:0] ss_addr, ss_dout, ss_rdat, buf_addr, buf_wdat;
  logic [7:0] buf_rdat = 8'h00;

  ss_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_save (start_save),
    .start_load (start_load),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ss_act     (ss_act),
    .ss_we      (ss_we),
    .ss_addr    (ss_addr),
    .ss_dout    (ss_dout),
    .ss_m2      (ss_m2),
    .ss_rdat    (ss_rdat),
    .buf_addr   (buf_addr),
    .buf_wdat   (buf_wdat),
    .buf_we     (buf_we),
    .buf_rdat   (buf_rdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mapper model: readback is addr^key, except map_idx at IDX when enabled.
  logic [7:0] mkey = 8'h00, map_idx = 8'h00;
  logic       idx_mode = 1'b0;
  assign ss_rdat = (idx_mode && ss_addr == IDX) ? map_idx : (ss_addr ^ mkey);

  // State buffer model with 1-clk read latency and a bulk fill port.
  logic [7:0] bmem [256];
  logic       fill_req = 1'b0, fill_rnd = 1'b0, fill_ovr = 1'b0;
  logic [7:0] fill_key = 8'h00, fill_idx = 8'h00;
  always @(posedge clk) begin
    if (fill_req) begin
      for (int k = 0; k < 256; k++)
        bmem[k] = fill_rnd ? 8'($urandom) : (8'(k) ^ fill_key);
      if (fill_ovr) bmem[IDX] = fill_idx;
    end else begin
      buf_rdat <= bmem[buf_addr];
      if (buf_we) bmem[buf_addr] = buf_wdat;
    end
  end

  // Mapper-side observer: latches on M2 falling edge only while ss_act && ss_we.
  logic [7:0] wlog_a [8192];
  logic [7:0] wlog_d [8192];
  int  wr_tot = 0, rise_tot = 0, bwr_tot = 0, swe_tot = 0, bad_tot = 0;
  int  done_tot = 0, done_cyc = 0;
  logic m2_prev = 1'b0;
  always @(negedge clk) begin
    if (ss_m2 && !m2_prev) rise_tot++;
    if (!ss_m2 && m2_prev && ss_act && ss_we && wr_tot < 8192) begin
      wlog_a[wr_tot] = ss_addr;
      wlog_d[wr_tot] = ss_dout;
      wr_tot++;
    end
    if (buf_we) bwr_tot++;
    if (ss_we) swe_tot++;
    if ((ss_m2 && !(ss_we && ss_act)) || (buf_we && ss_we)) bad_tot++;
    if (done) begin
      done_tot++;
      done_cyc = cyc;
    end
    m2_prev = ss_m2;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic rnd, input logic [7:0] key, input logic ovr, input logic [7:0] iv);
    fill_rnd = rnd; fill_key = key; fill_ovr = ovr; fill_idx = iv;
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
  endtask

  task automatic run_op(input logic sv, input logic ld, input int mid_ld,
                        output int lat, output int blo, output logic eacc, output logic ok);
    int c0, d0;
    start_save = sv; start_load = ld;
    c0 = cyc; d0 = done_tot;
    tick();
    start_save = 1'b0; start_load = 1'b0;
    eacc = err; ok = 1'b0; blo = 0; lat = 0;
    for (int n = 0; n < 4000; n++) begin
      if (done_tot != d0) begin
        ok = 1'b1;
        lat = done_cyc - c0;
        break;
      end
      if (!busy) blo++;
      start_load = (n == mid_ld);
      tick();
    end
    start_load = 1'b0;
  endtask

  typedef struct {
    logic sv; logic ld; logic rnd;
    logic [7:0] key; logic [7:0] idx; logic [7:0] map;
    logic exp_err; int exp_mwr; int exp_bwr;
  } vec_t;

  function automatic int save_bad(input logic [7:0] key);
    int b = 0;
    for (int k = 0; k < 256; k++) if (bmem[k] !== (8'(k) ^ key)) b++;
    return b;
  endfunction

  task automatic do_case(input vec_t v, input string nm);
    logic [7:0] exp_b [256];
    int   w0, r0, b0, s0, x0, lat, blo, bad;
    logic eacc, ok;
    fill(v.rnd, v.key, !v.sv, v.idx);
    mkey = v.key; map_idx = v.map; idx_mode = !v.sv;
    for (int k = 0; k < 256; k++) exp_b[k] = bmem[k];
    w0 = wr_tot; r0 = rise_tot; b0 = bwr_tot; s0 = swe_tot; x0 = bad_tot;
    run_op(v.sv, v.ld, -1, lat, blo, eacc, ok);
    chk({nm, "_done_seen"}, 32'(ok), 1);
    chk({nm, "_err"}, 32'(err), 32'(v.exp_err));
    chk({nm, "_err_clr_acc"}, 32'(eacc), 0);
    chk({nm, "_busy_cont"}, blo, 0);
    chk({nm, "_mapper_wr"}, wr_tot - w0, v.exp_mwr);
    chk({nm, "_m2_rises"}, rise_tot - r0, v.exp_mwr);
    chk({nm, "_buf_wr"}, bwr_tot - b0, v.exp_bwr);
    chk({nm, "_invariant"}, bad_tot - x0, 0);
    if (v.sv) begin
      chk({nm, "_save_lat"}, 32'(lat >= SAVE_LAT - 1 && lat <= SAVE_LAT + 1), 1);
      chk({nm, "_ss_we_in_save"}, swe_tot - s0, 0);
      chk({nm, "_buf_content"}, save_bad(v.key), 0);
    end else if (v.exp_mwr == 256) begin
      bad = 0;
      for (int j = 0; j < 256; j++)
        if (wlog_a[w0 + j] !== 8'(j) || wlog_d[w0 + j] !== exp_b[j]) bad++;
      chk({nm, "_wr_content"}, bad, 0);
    end
    tick();
    chk({nm, "_done_1cyc"}, {31'd0, done}, 0);
    chk({nm, "_act_off"}, {30'd0, ss_act, busy}, 0);
  endtask

  vec_t tbl [6];

  initial begin
    int   w0, r0, b0, lat, blo, bad;
    logic eacc, ok, found;
    vec_t v;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 0, 256};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h4D, 8'h4D, 1'b0, 256, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h4D, 8'h10, 1'b1, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h00, 1'b0, 0, 256};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 256, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h5A, 8'hFF, 8'hFE, 1'b1, 0, 0};

    rst_n = 1'b0;
    tick(); tick();
    chk("reset_ctrl", {26'd0, busy, done, err, ss_act, ss_we, ss_m2}, 0);
    chk("reset_buf_we", {31'd0, buf_we}, 0);
    chk("reset_data", {ss_addr, ss_dout, buf_addr, buf_wdat}, 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) do_case(tbl[t], $sformatf("vec%0d", t));

    // Random operations, expectations from the matching rule alone.
    for (int r = 0; r < 5; r++) begin
      v.sv  = 1'($urandom_range(0, 1));
      v.ld  = !v.sv || 1'($urandom_range(0, 1));
      v.rnd = 1'b1;
      v.key = 8'($urandom);
      v.idx = 8'($urandom);
      v.map = ($urandom_range(0, 1) == 1) ? v.idx : (v.idx ^ 8'($urandom_range(1, 255)));
      v.exp_err = !v.sv && (v.map != v.idx);
      v.exp_mwr = (!v.sv && !v.exp_err) ? 256 : 0;
      v.exp_bwr = v.sv ? 256 : 0;
      do_case(v, $sformatf("rnd%0d", r));
    end

    // Both commands together, plus a load pulsed mid-save.
    fill(1'b1, 8'h00, 1'b0, 8'h00);
    mkey = 8'h77; idx_mode = 1'b0;
    r0 = rise_tot; b0 = bwr_tot;
    run_op(1'b1, 1'b1, 100, lat, blo, eacc, ok);
    chk("mid_done_seen", 32'(ok), 1);
    chk("mid_busy_cont", blo, 0);
    chk("mid_no_m2", rise_tot - r0, 0);
    chk("mid_buf_wr", bwr_tot - b0, 256);
    chk("mid_content", save_bad(8'h77), 0);
    tick(); tick(); tick();
    chk("mid_not_queued", {31'd0, busy}, 0);

    // Reset while M2 is high for byte 40.
    fill(1'b0, 8'h00, 1'b1, 8'h4D);
    idx_mode = 1'b1; map_idx = 8'h4D;
    w0 = wr_tot;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      if (ss_m2 && ss_addr == 8'd40) found = 1'b1;
      else tick();
    end
    chk("rst_reach_b40", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {29'd0, ss_m2, ss_act, busy}, 0);
    chk("rst_async_addr", {ss_addr, buf_addr}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_wr_count", wr_tot - w0, 40);
    bad = 0;
    for (int j = w0; j < wr_tot; j++) if (wlog_a[j] == 8'd40) bad++;
    chk("rst_no_wr40", bad, 0);
    v = '{1'b1, 1'b0, 1'b1, 8'hC3, 8'h00, 8'h00, 1'b0, 0, 256};
    do_case(v, "post_rst_save");

    // Back-to-back: failing load, then save and load each issued the cycle after done.
    fill(1'b1, 8'h00, 1'b1, 8'h21);
    idx_mode = 1'b1; map_idx = 8'h22;
    run_op(1'b0, 1'b1, -1, lat, blo, eacc, ok);
    chk("b2b_mis_err", 32'(err), 1);
    tick();
    chk("b2b_err_sticky", 32'(err), 1);
    idx_mode = 1'b0; mkey = 8'h5A;
    b0 = bwr_tot;
    run_op(1'b1, 1'b0, -1, lat, blo, eacc, ok);
    chk("b2b_save_ok", 32'(ok), 1);
    chk("b2b_save_err_clr", 32'(eacc), 0);
    chk("b2b_save_bwr", bwr_tot - b0, 256);
    tick();
    idx_mode = 1'b1; map_idx = IDX ^ 8'h5A;
    w0 = wr_tot;
    run_op(1'b0, 1'b1, -1, lat, blo, eacc, ok);
    chk("b2b_load_ok", 32'(ok), 1);
    chk("b2b_load_err", 32'(err), 0);
    chk("b2b_load_wr", wr_tot - w0, 256);
    bad = 0;
    for (int j = 0; j < 256; j++)
      if (wlog_a[w0 + j] !== 8'(j) || wlog_d[w0 + j] !== (8'(j) ^ 8'h5A)) bad++;
    chk("b2b_load_content", bad, 0);
    chk("final_invariant", bad_tot, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
